// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: start/done bus of the sequential multiplier.
// The requester drives start/A/B (master). The multiplier drives busy/done/out (slave).
interface seq_multiplier_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] out;

  modport master (
    output start, A, B,
    input  busy, done, out
  );

  modport slave (
    input  start, A, B,
    output busy, done, out
  );
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier with a full 2*WIDTH-bit product.
// An operation takes WIDTH+2 cycles from the accepting edge to the next possible accept.
// Optional feature macro: SEQ_MULT_SIGNED_EN selects two's complement operands and product.
//
// Handshake: start is sampled only while IDLE. The edge that samples it also
// captures A/B, and any later start is ignored until the block is back in IDLE.
// done is a one-cycle pulse WIDTH+1 edges after the accept. out changes only
// with that pulse (or on reset) and holds its value until the next one. busy
// covers the accept edge through the edge where done falls.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_multiplier_if.slave   bus,
  output logic [1:0]        dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   out_q, out_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic [2*WIDTH-1:0]   result;
`ifdef SEQ_MULT_SIGNED_EN
  logic                 sign_q, sign_d;
  logic [WIDTH-1:0]     a_mag, b_mag;
`endif

`ifdef SEQ_MULT_SIGNED_EN
  // Magnitudes of the operands; the most negative value maps to 2^(WIDTH-1), which fits unsigned
  always_comb begin
    a_mag = bus.A[WIDTH-1] ? (~bus.A + 1'b1) : bus.A;
    b_mag = bus.B[WIDTH-1] ? (~bus.B + 1'b1) : bus.B;
  end

  // Final product: restore the sign of the unsigned accumulator
  always_comb begin
    result = sign_q ? (~acc_q + 1'b1) : acc_q;
  end
`else
  // Final product is the accumulator as-is in the unsigned build
  always_comb begin
    result = acc_q;
  end
`endif

  // Next-state and datapath: capture, WIDTH add/shift iterations, then one result cycle
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    done_d   = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
    sign_d   = sign_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
`ifdef SEQ_MULT_SIGNED_EN
          mcand_d  = a_mag;
          mplier_d = b_mag;
          sign_d   = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
`else
          mcand_d  = bus.A;
          mplier_d = bus.B;
`endif
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + ({{WIDTH{1'b0}}, mcand_q} << cnt_q);
        end
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_d   = result;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // busy stays up through the cycle in which done is high
    busy_d = (state_d != IDLE) || done_d;
  end

  // State and registered outputs; reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      sign_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef SEQ_MULT_SIGNED_EN
      sign_q   <= sign_d;
`endif
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.out   = out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed vectors for seq_multiplier at WIDTH=8 and WIDTH=2.
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_seq_multiplier;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state8;
  logic [1:0] dbg_state2;
  int         n_checks;
  int         n_errors;

  seq_multiplier_if #(.WIDTH(8)) m8 ();
  seq_multiplier_if #(.WIDTH(2)) m2 ();

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (m8.slave),
    .dbg_state (dbg_state8)
  );

  seq_multiplier #(.WIDTH(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (m2.slave),
    .dbg_state (dbg_state2)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full operation on the WIDTH=8 unit: latency, busy length, product, and quiet afterwards
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input string tag);
    int lat;
    int busy_cnt;
    @(negedge clk);
    m8.start = 1'b1; m8.A = a; m8.B = b;
    @(negedge clk);                       // after edge 0 (accept)
    m8.start = 1'b0;
    m8.A = 8'($urandom_range(0, 255));    // operands may change after capture
    m8.B = 8'($urandom_range(0, 255));
    lat = 0;
    busy_cnt = 0;
    while (!m8.done && lat < 30) begin
      busy_cnt += int'(m8.busy);
      @(negedge clk);
      lat++;
    end
    busy_cnt += int'(m8.busy);
    check_eq({tag, "_latency"}, 32'(lat), 32'd9);
    check_eq({tag, "_out"}, 32'(m8.out), 32'(exp));
    check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd10);
    @(negedge clk);                       // after edge 10
    check_eq({tag, "_done_fall"}, 32'(m8.done), 32'd0);
    check_eq({tag, "_busy_fall"}, 32'(m8.busy), 32'd0);
    check_eq({tag, "_out_hold"}, 32'(m8.out), 32'(exp));
  endtask

  // One operation on the WIDTH=2 unit: latency and product
  task automatic run_op2(input logic [1:0] a, input logic [1:0] b,
                         input logic [3:0] exp, input string tag);
    int lat;
    @(negedge clk);
    m2.start = 1'b1; m2.A = a; m2.B = b;
    @(negedge clk);
    m2.start = 1'b0;
    lat = 0;
    while (!m2.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'd3);
    check_eq({tag, "_out"}, 32'(m2.out), 32'(exp));
    @(negedge clk);
    check_eq({tag, "_done_fall"}, 32'(m2.done), 32'd0);
  endtask

  initial begin
    int done_cnt;
    int done_edge;
    logic [15:0] done_out;
    int done_edge2;
    logic [15:0] done_out2;

    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    m8.start = 1'b0; m8.A = '0; m8.B = '0;
    m2.start = 1'b0; m2.A = '0; m2.B = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_busy8", 32'(m8.busy), 32'd0);
    check_eq("rst_done8", 32'(m8.done), 32'd0);
    check_eq("rst_out8", 32'(m8.out), 32'd0);
    check_eq("rst_state8", 32'(dbg_state8), 32'd0);
    check_eq("rst_busy2", 32'(m2.busy), 32'd0);
    check_eq("rst_out2", 32'(m2.out), 32'd0);
    rst_n = 1'b1;

    // WIDTH=2 vectors
    run_op2(2'b01, 2'b01, 4'b0001, "w2_1x1");
`ifdef SEQ_MULT_SIGNED_EN
    run_op2(2'b11, 2'b11, 4'b0001, "w2_m1xm1");
`else
    run_op2(2'b11, 2'b11, 4'b1001, "w2_3x3");
`endif

    // WIDTH=8 main vectors
`ifdef SEQ_MULT_SIGNED_EN
    run_op8(8'd255, 8'd255, 16'h0001, "w8_m1xm1");
    run_op8(8'hFD, 8'd5, 16'hFFF1, "s_m3x5");
    run_op8(8'h80, 8'h80, 16'h4000, "s_m128xm128");
    run_op8(8'hFF, 8'h01, 16'hFFFF, "s_m1x1");
`else
    run_op8(8'd255, 8'd255, 16'hFE01, "w8_255x255");
    run_op8(8'd13, 8'd11, 16'd143, "w8_13x11");
`endif
    run_op8(8'd0, 8'd200, 16'd0, "w8_0x200");

    // start re-pulsed during CALC and DONE: only the first operation completes
    @(negedge clk);
    m8.start = 1'b1; m8.A = 8'd20; m8.B = 8'd30;
    done_cnt = 0; done_edge = -1; done_out = '0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);                     // after edge n
      if (m8.done) begin
        done_cnt++; done_edge = n; done_out = m8.out;
      end
      m8.start = (n == 3 || n == 8);
      m8.A = 8'd100; m8.B = 8'd100;
    end
    check_eq("repulse_done_count", 32'(done_cnt), 32'd1);
    check_eq("repulse_done_edge", 32'(done_edge), 32'd9);
    check_eq("repulse_out", 32'(done_out), 32'd600);
    check_eq("repulse_busy_end", 32'(m8.busy), 32'd0);

    // Reset in the middle of CALC
    @(negedge clk);
    m8.start = 1'b1; m8.A = 8'd50; m8.B = 8'd60;
    @(negedge clk);                       // after edge 0
    m8.start = 1'b0;
    repeat (3) @(negedge clk);            // after edge 3
    check_eq("midrst_busy_before", 32'(m8.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(m8.busy), 32'd0);
    check_eq("midrst_done", 32'(m8.done), 32'd0);
    check_eq("midrst_out", 32'(m8.out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      done_cnt += int'(m8.done);
    end
    check_eq("midrst_no_done", 32'(done_cnt), 32'd0);
    check_eq("midrst_idle", 32'(dbg_state8), 32'd0);
    run_op8(8'd12, 8'd10, 16'd120, "post_rst_12x10");

    // start held high: 3x7 accepted at edge 0, 9x9 at edge 10
    @(negedge clk);
    m8.start = 1'b1; m8.A = 8'd3; m8.B = 8'd7;
    done_cnt = 0; done_edge = -1; done_out = '0; done_edge2 = -1; done_out2 = '0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);                     // after edge n
      if (m8.done) begin
        if (done_cnt == 0) begin
          done_edge = n; done_out = m8.out;
        end else begin
          done_edge2 = n; done_out2 = m8.out;
        end
        done_cnt++;
      end
      if (n == 15) check_eq("held_out_hold", 32'(m8.out), 32'd21);
      if (n == 0) begin
        m8.A = 8'd9; m8.B = 8'd9;
      end
      if (n == 10) m8.start = 1'b0;
    end
    check_eq("held_done_count", 32'(done_cnt), 32'd2);
    check_eq("held_edge1", 32'(done_edge), 32'd9);
    check_eq("held_out1", 32'(done_out), 32'd21);
    check_eq("held_edge2", 32'(done_edge2), 32'd19);
    check_eq("held_out2", 32'(done_out2), 32'd81);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
